// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
// pipeline_stall_controller_if : hazard requests in, stage enables/flushes out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             load_use_hazard;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             mdu_start;
  logic             mdu_done;
  logic             perf_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state;

  modport master (
    output load_use_hazard, branch_taken, dmem_req, dmem_ready,
           mdu_start, mdu_done, perf_clr,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout_err,
           stall_count, state
  );

  modport slave (
    input  load_use_hazard, branch_taken, dmem_req, dmem_ready,
           mdu_start, mdu_done, perf_clr,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout_err,
           stall_count, state
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// pipeline_stall_controller : stall/flush sequencer for the 5-stage pipeline
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  pipeline_stall_controller_if.slave bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  // Control vector: {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f}
  localparam logic [7:0] c_DEF    = 8'b11111_000;
  localparam logic [7:0] c_FREEZE = 8'b00000_000;
  localparam logic [7:0] c_MDU    = 8'b00011_001;
  localparam logic [7:0] c_BRANCH = 8'b11111_110;
  localparam logic [7:0] c_LDUSE  = 8'b00111_010;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       w_ctrl;
  logic             w_mem_stall;
  logic             w_mdu_stall;
  logic             w_apply_mdu;
  logic             w_apply_ctl;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_tmo_err;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_mem_stall = bus.dmem_req & ~bus.dmem_ready;
  assign w_mdu_stall = bus.mdu_start & ~bus.mdu_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_RUN;
    w_ctrl       = c_DEF;
    w_apply_mdu  = 1'b0;
    w_apply_ctl  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_ctrl       = c_FREEZE;
          w_state_next = ST_MEM_WAIT;
        end else begin
          w_apply_mdu = 1'b1;
          w_apply_ctl = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          w_ctrl       = c_FREEZE;
          w_state_next = ST_MEM_WAIT;
        end else begin
          w_apply_mdu = 1'b1;
          w_apply_ctl = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (w_mem_stall) begin
          w_ctrl       = c_FREEZE;
          w_state_next = ST_MEM_WAIT;
        end else if (!bus.mdu_done) begin
          w_ctrl       = c_MDU;
          w_state_next = ST_MDU_WAIT;
        end else begin
          w_apply_ctl = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Lower-priority rules for a cycle that is not held by a memory stall
    if (w_apply_mdu && w_mdu_stall) begin
      w_ctrl       = c_MDU;
      w_state_next = ST_MDU_WAIT;
    end else if (w_apply_ctl && bus.branch_taken) begin
      w_ctrl = c_BRANCH;
    end else if (w_apply_ctl && bus.load_use_hazard) begin
      w_ctrl = c_LDUSE;
    end
  end

  // r_tmo_cnt holds the 1-based index of the current MEM_WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == ST_MEM_WAIT && w_state_next == ST_MEM_WAIT) begin
        if (r_tmo_cnt != TW'(MEM_TIMEOUT))
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (r_tmo_cnt >= TW'(MEM_TIMEOUT - 1))
          r_tmo_err <= 1'b1;
      end else if (w_state_next == ST_MEM_WAIT) begin
        r_tmo_cnt <= TW'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (bus.perf_clr)
      r_stall_cnt <= '0;
    else if (!w_ctrl[7] && r_stall_cnt != {CNT_W{1'b1}})
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.pc_write        = w_ctrl[7];
  assign bus.if_id_write     = w_ctrl[6];
  assign bus.id_ex_write     = w_ctrl[5];
  assign bus.ex_mem_write    = w_ctrl[4];
  assign bus.mem_wb_write    = w_ctrl[3];
  assign bus.if_id_flush     = w_ctrl[2];
  assign bus.id_ex_flush     = w_ctrl[1];
  assign bus.ex_mem_flush    = w_ctrl[0];
  assign bus.mem_timeout_err = r_tmo_err;
  assign bus.stall_count     = r_stall_cnt;
  assign bus.state           = r_state;

endmodule

`default_nettype wire
